retire_trace_tx: RTL and testbench

RETIRE_TRACE_TX -- requirements
Module: retire_trace_tx

---
 rtl/retire_trace_tx.sv | 152 +++++++++++++++
 tb/tb_retire_trace_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_tx.sv
// retire_trace_tx: captures one record per retired instruction into a small
// FIFO and presents it on a valid/ready trace port. Records that arrive while
// the FIFO is full and not draining are dropped and counted, and the
// sequence number is only advanced for records that are actually stored.
module retire_trace_tx #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ret_valid,
  input  logic [31:0] ret_pc,
  input  logic [31:0] ret_instr,
  input  logic        ret_is_r,
  input  logic        ret_is_i,
  input  logic        ret_is_j,
  input  logic        ret_wr_en,
  input  logic [4:0]  ret_wr_reg,
  input  logic [31:0] ret_wr_data,
  input  logic        clr_stat,
  output logic        trc_valid,
  input  logic        trc_ready,
  output logic [31:0] trc_pc,
  output logic [31:0] trc_instr,
  output logic [1:0]  trc_type,
  output logic        trc_wr_en,
  output logic [4:0]  trc_wr_reg,
  output logic [31:0] trc_wr_data,
  output logic [15:0] trc_seq,
  output logic        stall_req,
  output logic        overflow,
  output logic [7:0]  drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  rtype;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic [15:0] seq;
  } rec_t;

  // Storage has no reset: the head is masked whenever the FIFO is empty.
  rec_t mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   seq_q, seq_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic full, pop, push, drop;
  rec_t new_rec;
  rec_t head_rec;

  assign full = (count_q == CW'(DEPTH));
  assign pop  = (count_q != '0) && trc_ready;
  // A pop frees the slot on the same edge, so a full FIFO can still accept.
  assign push = ret_valid && (!full || pop);
  assign drop = ret_valid && full && !pop;

  // Build the record for the retiring instruction (r0 writes are suppressed).
  always_comb begin
    new_rec       = '0;
    new_rec.pc    = ret_pc;
    new_rec.instr = ret_instr;
    if (ret_is_r)      new_rec.rtype = 2'b01;
    else if (ret_is_i) new_rec.rtype = 2'b10;
    else if (ret_is_j) new_rec.rtype = 2'b11;
    else               new_rec.rtype = 2'b00;
    new_rec.wr_en = ret_wr_en && (ret_wr_reg != 5'd0);
    if (new_rec.wr_en) begin
      new_rec.wr_reg  = ret_wr_reg;
      new_rec.wr_data = ret_wr_data;
    end
    new_rec.seq = seq_q;
  end

  // Next-state for pointers, occupancy, sequence number and drop statistics.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    seq_d      = seq_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      seq_d    = seq_q + 16'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Clearing takes priority over a drop on the same edge.
    if (clr_stat) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Record storage write; when full, the slot written is the one being popped.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_rec;
  end

  assign head_rec = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

  assign trc_valid   = (count_q != '0);
  assign trc_pc      = head_rec.pc;
  assign trc_instr   = head_rec.instr;
  assign trc_type    = head_rec.rtype;
  assign trc_wr_en   = head_rec.wr_en;
  assign trc_wr_reg  = head_rec.wr_reg;
  assign trc_wr_data = head_rec.wr_data;
  assign trc_seq     = head_rec.seq;
  assign stall_req   = (count_q >= CW'(DEPTH - 1));
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_retire_trace_tx.sv
// Bench for retire_trace_tx: a reference queue holds the records that should
// be in the FIFO; the head is compared against the trace port every cycle.
module tb_retire_trace_tx;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ret_valid, ret_is_r, ret_is_i, ret_is_j, ret_wr_en;
  logic [31:0] ret_pc, ret_instr, ret_wr_data;
  logic [4:0]  ret_wr_reg;
  logic        clr_stat, trc_ready;
  logic        trc_valid, trc_wr_en, stall_req, overflow;
  logic [31:0] trc_pc, trc_instr, trc_wr_data;
  logic [1:0]  trc_type;
  logic [4:0]  trc_wr_reg;
  logic [15:0] trc_seq;
  logic [7:0]  drop_cnt;

  retire_trace_tx #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ret_valid(ret_valid), .ret_pc(ret_pc),
    .ret_instr(ret_instr), .ret_is_r(ret_is_r), .ret_is_i(ret_is_i),
    .ret_is_j(ret_is_j), .ret_wr_en(ret_wr_en), .ret_wr_reg(ret_wr_reg),
    .ret_wr_data(ret_wr_data), .clr_stat(clr_stat), .trc_valid(trc_valid),
    .trc_ready(trc_ready), .trc_pc(trc_pc), .trc_instr(trc_instr),
    .trc_type(trc_type), .trc_wr_en(trc_wr_en), .trc_wr_reg(trc_wr_reg),
    .trc_wr_data(trc_wr_data), .trc_seq(trc_seq), .stall_req(stall_req),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  rtype;
    logic        wen;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [15:0] seq;
  } exp_t;

  typedef struct {
    logic [2:0]  cls;      // {r, i, j}
    logic        wen;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [1:0]  e_type;
    logic        e_wen;
    logic [4:0]  e_wreg;
    logic [31:0] e_wdata;
  } vec_t;

  exp_t        sb[$];
  logic [15:0] m_seq;
  logic        m_ovf;
  logic [7:0]  m_drop;
  logic [31:0] pc_ctr;
  int          n_vec = 0;
  int          n_err = 0;
  vec_t        vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] cls, input logic wen,
                       input logic [4:0] wreg, input logic [31:0] wdata, input logic rdy);
    ret_valid   = v;
    ret_is_r    = cls[2];
    ret_is_i    = cls[1];
    ret_is_j    = cls[0];
    ret_wr_en   = wen;
    ret_wr_reg  = wreg;
    ret_wr_data = wdata;
    ret_pc      = pc_ctr;
    ret_instr   = $urandom;
    pc_ctr      = pc_ctr + 32'd4;
    trc_ready   = rdy;
  endtask

  task automatic push(input logic rdy);
    drive(1'b1, 3'b100, 1'b1, 5'($urandom_range(1, 31)), $urandom, rdy);
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 3'b000, 1'b0, 5'd0, 32'd0, rdy);
  endtask

  task automatic check_outputs();
    chk("trc_valid", 32'(trc_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("trc_pc", trc_pc, sb[0].pc);
      chk("trc_instr", trc_instr, sb[0].instr);
      chk("trc_type", 32'(trc_type), 32'(sb[0].rtype));
      chk("trc_wr_en", 32'(trc_wr_en), 32'(sb[0].wen));
      chk("trc_wr_reg", 32'(trc_wr_reg), 32'(sb[0].wreg));
      chk("trc_wr_data", trc_wr_data, sb[0].wdata);
      chk("trc_seq", 32'(trc_seq), 32'(sb[0].seq));
    end else begin
      chk("idle_payload", trc_pc | trc_instr | trc_wr_data | 32'(trc_seq) |
          32'(trc_type) | 32'(trc_wr_reg) | 32'(trc_wr_en), 32'd0);
    end
    chk("stall_req", 32'(stall_req), 32'(sb.size() >= DEPTH - 1));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  // One clock: check outputs mid-cycle, advance the model, return after the edge.
  task automatic tick();
    exp_t e;
    logic pop_m, push_m;
    @(negedge clk);
    check_outputs();
    pop_m  = (sb.size() != 0) && trc_ready;
    push_m = ret_valid && ((sb.size() < DEPTH) || pop_m);
    if (pop_m) begin
      e = sb.pop_front();
      $display("pop  seq=%0d pc=%08h type=%0d wen=%0d", e.seq, e.pc, e.rtype, e.wen);
    end
    if (push_m) begin
      e.pc    = ret_pc;
      e.instr = ret_instr;
      e.rtype = ret_is_r ? 2'b01 : ret_is_i ? 2'b10 : ret_is_j ? 2'b11 : 2'b00;
      e.wen   = ret_wr_en && (ret_wr_reg != 5'd0);
      e.wreg  = e.wen ? ret_wr_reg : 5'd0;
      e.wdata = e.wen ? ret_wr_data : 32'd0;
      e.seq   = m_seq;
      sb.push_back(e);
      m_seq = m_seq + 16'd1;
    end
    if (clr_stat) begin
      m_ovf  = 1'b0;
      m_drop = 8'd0;
    end else if (ret_valid && !push_m) begin
      m_ovf = 1'b1;
      if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    sb.delete();
    m_seq  = 16'd0;
    m_ovf  = 1'b0;
    m_drop = 8'd0;
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    reset     = 1'b1;
    ret_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{3'b100, 1'b1, 5'd5,  32'h0000AAAA, 2'b01, 1'b1, 5'd5,  32'h0000AAAA};
    vt[1] = '{3'b010, 1'b0, 5'd7,  32'h00005555, 2'b10, 1'b0, 5'd0,  32'h00000000};
    vt[2] = '{3'b001, 1'b1, 5'd31, 32'hDEADBEEF, 2'b11, 1'b1, 5'd31, 32'hDEADBEEF};
    vt[3] = '{3'b000, 1'b1, 5'd3,  32'h00000077, 2'b00, 1'b1, 5'd3,  32'h00000077};
    vt[4] = '{3'b111, 1'b0, 5'd2,  32'h00000001, 2'b01, 1'b0, 5'd0,  32'h00000000};
    vt[5] = '{3'b011, 1'b1, 5'd0,  32'h00001234, 2'b10, 1'b0, 5'd0,  32'h00000000};
    vt[6] = '{3'b101, 1'b1, 5'd0,  32'h00001234, 2'b01, 1'b0, 5'd0,  32'h00000000};
    vt[7] = '{3'b010, 1'b1, 5'd1,  32'hFFFFFFFF, 2'b10, 1'b1, 5'd1,  32'hFFFFFFFF};

    reset    = 1'b1;
    clr_stat = 1'b0;
    pc_ctr   = 32'h0000_1000;
    idle(1'b0);
    #2;
    apply_reset();

    // Three back-to-back pushes with a ready consumer: seq 0,1,2 one cycle later.
    for (int k = 0; k < 3; k++) begin
      push(1'b1);
      tick();
      chk("in_order_seq", 32'(trc_seq), k);
    end
    idle(1'b1);
    tick();
    tick();

    // Table of class / register-write encodings, including a write to r0.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, vt[k].cls, vt[k].wen, vt[k].wreg, vt[k].wdata, 1'b1);
      tick();
      chk("vec_type", 32'(trc_type), 32'(vt[k].e_type));
      chk("vec_wr_en", 32'(trc_wr_en), 32'(vt[k].e_wen));
      chk("vec_wr_reg", 32'(trc_wr_reg), 32'(vt[k].e_wreg));
      chk("vec_wr_data", trc_wr_data, vt[k].e_wdata);
    end
    idle(1'b1);
    tick();
    tick();

    // Fill with a stalled consumer, then one more push to force a drop.
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      push(1'b0);
      tick();
      if (k == 1) chk("stall_after_2", 32'(stall_req), 32'd0);
      if (k == 2) chk("stall_after_3", 32'(stall_req), 32'd1);
    end
    chk("ovf_after_drop", 32'(overflow), 32'd1);
    chk("drop_cnt_1", 32'(drop_cnt), 32'd1);
    chk("held_head_seq", 32'(trc_seq), 32'd0);

    // Full FIFO, push and pop together: oldest leaves, no drop, count holds.
    push(1'b1);
    tick();
    chk("full_pp_head", 32'(trc_seq), 32'd1);
    chk("full_pp_drop", 32'(drop_cnt), 32'd1);
    chk("full_pp_stall", 32'(stall_req), 32'd1);
    idle(1'b1);
    tick();
    tick();
    tick();
    chk("seq_after_drop", 32'(trc_seq), 32'd4);
    tick();
    chk("drained", 32'(trc_valid), 32'd0);

    // Saturate the drop counter, then clear while a drop lands on the same edge.
    apply_reset();
    for (int k = 0; k < DEPTH + 300; k++) begin
      push(1'b0);
      tick();
    end
    chk("drop_cnt_sat", 32'(drop_cnt), 32'hFF);
    chk("ovf_sat", 32'(overflow), 32'd1);
    push(1'b0);
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    idle(1'b0);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_drop_cnt", 32'(drop_cnt), 32'd0);
    tick();
    idle(1'b1);
    for (int k = 0; k < DEPTH + 1; k++) tick();

    // Reset with two records buffered: they vanish at once, seq restarts at 0.
    push(1'b0);
    tick();
    push(1'b0);
    tick();
    idle(1'b0);
    reset = 1'b0;
    #1;
    chk("reset_valid_now", 32'(trc_valid), 32'd0);
    apply_reset();
    push(1'b0);
    tick();
    chk("post_reset_seq", 32'(trc_seq), 32'd0);
    idle(1'b1);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
